alu_execute_stage: RTL and testbench
====================================

Name: alu_execute_stage

Overview:
Execute stage directly downstream of the register file.
- Consumes the SR1/SR2 operand pair and an immediate, and computes ADD/AND/NOT (optionally MUL).
- Drives the write-back triple back into the register file: Result to In, DR to DR, and a one-cycle LD_REG pulse.
- Maintains the NZP condition-code register on every write-back.

Parameters:
WIDTH, 16, datapath width
IMM_WIDTH, 5, immediate field width, sign-extended to WIDTH
MUL_CYCLES, 16, iterations of the optional multiplier (equals WIDTH)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only while Busy=0
Op  input  2  00 ADD, 01 AND, 10 NOT, 11 MUL
SR1_In  input  WIDTH  operand A (register file SR1_Out)
SR2_In  input  WIDTH  operand B (register file SR2_Out)
Imm  input  IMM_WIDTH  immediate field
ImmSel  input  1  1 = operand B is sext(Imm)
DR_In  input  3  destination register index
Busy  output  1  high whenever state != IDLE
LD_REG  output  1  write-back strobe to the register file
DR  output  3  registered destination index
Result  output  WIDTH  registered result
N, Z, P  output  1 each  condition codes

Behaviour:
- Clock and reset are fixed: one clock Clk; Reset is asynchronous, active-high.
- Reset values: state=IDLE, Busy=0, LD_REG=0, DR=0, Result=0, N=0, Z=1, P=0.
- States: IDLE, MUL, WB.
- IDLE:
  - Start=1 latches Op, DR_In, A=SR1_In, and B = ImmSel ? sext(Imm) : SR2_In.
  - ADD/AND/NOT go to WB, with Result loaded on the same edge.
  - MUL goes to MUL (feature enabled only).
- Arithmetic:
  - ADD: A+B mod 2^WIDTH, carry discarded.
  - AND: A&B.
  - NOT: ~A; B and ImmSel are ignored.
- MUL: shift-add, one partial product per cycle, 4-bit counter. After MUL_CYCLES cycles, Result = low WIDTH bits of A*B (unsigned; identical low bits for two's complement), then go to WB.
- WB lasts exactly one cycle with LD_REG=1. DR and Result are stable during it.
- On the edge ending WB: N/Z/P load from Result (N=Result[15]; Z = Result==0; P = otherwise; exactly one set). State returns to IDLE.
- Latency, Start edge to LD_REG high:
  - ADD/AND/NOT: 1 cycle.
  - MUL: MUL_CYCLES+1 cycles.
- Throughput: one ALU op every 2 cycles.
- Start while Busy=1 is ignored; it is neither queued nor errored.
- Operands are captured at accept. SR1_In/SR2_In changes afterwards do not affect the result. This covers the case where the write-back target equals a source register.
- Op=11 with the feature disabled: accepted, returns to IDLE after one cycle in WB with LD_REG held 0. Result, DR and NZP are unchanged.
- Reset asserted mid-MUL or in WB: immediate return to reset values. No LD_REG pulse is emitted.
- Result and DR outputs hold their last value in IDLE.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: the MUL state and multiplier datapath exist; Op=11 performs the multiply as specified.
- Undefined: the MUL state and datapath are absent; Op=11 is a NOP as described in Behaviour.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (ADD, AND, NOT, MUL).
  - alu_state_t enum (IDLE, MUL, WB).
  - WIDTH and IMM_WIDTH constants.
  - sext function.
  - nzp_t struct.
- One sub-module, shift_add_multiplier: load/start input, done output, WIDTH-bit product.
  - Instantiated only under ALU_MUL_EN.
  - The FSM in alu_execute_stage waits on its done.

Test Plan:
- Reset, then check outputs: Result=0, DR=0, LD_REG=0, Busy=0, NZP=010. Issue ADD, SR1=0x0005, Imm=5'b11101 (-3), ImmSel=1, DR_In=3 -> next cycle LD_REG=1, Result=0x0002, DR=3; afterwards NZP=001.
- AND 0xF0F0 & 0x0FF0 (ImmSel=0) -> Result=0x00F0. Then NOT 0xFFFF -> Result=0x0000, Z=1. Then ADD 0x7FFF+0x0001 -> Result=0x8000, N=1.
- Start held high for 4 cycles with ADD 1+1 -> exactly two LD_REG pulses, two cycles apart, each Result=0x0002. Busy alternates 1/0.
- ALU_MUL_EN defined: MUL 0x0012*0x0034 -> Busy=1 for 17 cycles; LD_REG 17 cycles after Start with Result=0x03A8. Repeat 0xFFFF*0x0003 -> Result=0xFFFD, N=1.
- ALU_MUL_EN undefined: Op=11 -> no LD_REG, Result/DR/NZP unchanged, Busy for 1 cycle.
- ALU_MUL_EN defined: Reset pulsed 5 cycles into a MUL -> all outputs return to reset values immediately, no LD_REG. The next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, constants and helpers for the ALU execute stage.
package alu_pkg;

   localparam int WIDTH      = 16;
   localparam int IMM_WIDTH  = 5;
   localparam int MUL_CYCLES = WIDTH;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_AND = 2'b01,
      OP_NOT = 2'b10,
      OP_MUL = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_WB   = 2'b10
   } alu_state_t;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } nzp_t;

   localparam nzp_t NZP_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0};

   function automatic logic [WIDTH-1:0] sext(input logic [IMM_WIDTH-1:0] imm);
      return {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   endfunction

   function automatic nzp_t nzp_of(input logic [WIDTH-1:0] value);
      nzp_t cc;
      cc.n = value[WIDTH-1];
      cc.z = (value == '0);
      cc.p = !cc.n && !cc.z;
      return cc;
   endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// Request / write-back bundle between the register file side and the execute stage.
interface alu_execute_stage_if;
   import alu_pkg::*;

   logic                 Start;
   logic [1:0]           Op;
   logic [WIDTH-1:0]     SR1_In;
   logic [WIDTH-1:0]     SR2_In;
   logic [IMM_WIDTH-1:0] Imm;
   logic                 ImmSel;
   logic [2:0]           DR_In;
   logic                 Busy;
   logic                 LD_REG;
   logic [2:0]           DR;
   logic [WIDTH-1:0]     Result;
   logic                 N;
   logic                 Z;
   logic                 P;

   modport master (
      output Start, Op, SR1_In, SR2_In, Imm, ImmSel, DR_In,
      input  Busy, LD_REG, DR, Result, N, Z, P
   );

   modport slave (
      input  Start, Op, SR1_In, SR2_In, Imm, ImmSel, DR_In,
      output Busy, LD_REG, DR, Result, N, Z, P
   );

endinterface

// File: rtl/alu_execute_stage_shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, MUL_CYCLES cycles
// after load. done is high during the final iteration, when product is the full result.
module shift_add_multiplier
   import alu_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(MUL_CYCLES);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] partial;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;

   // Only the low WIDTH bits are kept, so bits shifted out of a_q never matter.
   assign partial = b_q[0] ? a_q : '0;
   assign product = acc_q + partial;
   assign done    = run_q && (cnt_q == CNT_W'(MUL_CYCLES-1));

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (load) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         acc_q <= product;
         a_q   <= {a_q[WIDTH-2:0], 1'b0};
         b_q   <= {1'b0, b_q[WIDTH-1:1]};
         cnt_q <= cnt_q + CNT_W'(1);
         if (done) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: ADD/AND/NOT in one cycle, write-back strobe and NZP update.
// Define ALU_MUL_EN to add the iterative multiplier for Op=11; otherwise Op=11 is a NOP.
module alu_execute_stage
   import alu_pkg::*;
(
   input logic                 Clk,
   input logic                 Reset,
   alu_execute_stage_if.slave  bus
);

   alu_state_t       state_q;
   alu_state_t       state_d;
   alu_op_t          op_in;
   logic             accept;
   logic             op_valid;
   logic             mul_load;
   logic             wb_en_q;
   logic [2:0]       dr_q;
   logic [WIDTH-1:0] result_q;
   nzp_t             nzp_q;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] alu_res;

   assign op_in  = alu_op_t'(bus.Op);
   assign opnd_a = bus.SR1_In;
   assign opnd_b = bus.ImmSel ? sext(bus.Imm) : bus.SR2_In;

`ifdef ALU_MUL_EN
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign op_valid = 1'b1;

   shift_add_multiplier u_mul (
      .Clk     (Clk),
      .Reset   (Reset),
      .load    (mul_load),
      .a       (opnd_a),
      .b       (opnd_b),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   // Without the multiplier, Op=11 still occupies WB for a cycle but writes nothing back.
   assign op_valid = (op_in != OP_MUL);
`endif

   always_comb begin
      alu_res = '0;
      unique case (op_in)
         OP_ADD:  alu_res = opnd_a + opnd_b;
         OP_AND:  alu_res = opnd_a & opnd_b;
         OP_NOT:  alu_res = ~opnd_a;
         default: alu_res = '0;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      mul_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               accept = 1'b1;
`ifdef ALU_MUL_EN
               if (op_in == OP_MUL) begin
                  mul_load = 1'b1;
                  state_d  = ST_MUL;
               end else begin
                  state_d  = ST_WB;
               end
`else
               state_d = ST_WB;
`endif
            end
         end
`ifdef ALU_MUL_EN
         ST_MUL: begin
            if (mul_done) begin
               state_d = ST_WB;
            end
         end
`endif
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wb_en_q  <= 1'b0;
         dr_q     <= '0;
         result_q <= '0;
         nzp_q    <= NZP_RESET;
      end else begin
         if (accept) begin
            wb_en_q <= op_valid;
            if (op_valid) begin
               dr_q <= bus.DR_In;
            end
            if (op_in != OP_MUL) begin
               result_q <= alu_res;
            end
         end
`ifdef ALU_MUL_EN
         if (state_q == ST_MUL && mul_done) begin
            result_q <= mul_product;
         end
`endif
         if (state_q == ST_WB && wb_en_q) begin
            nzp_q <= nzp_of(result_q);
         end
      end
   end

   assign bus.Busy   = (state_q != ST_IDLE);
   assign bus.LD_REG = (state_q == ST_WB) && wb_en_q;
   assign bus.DR     = dr_q;
   assign bus.Result = result_q;
   assign bus.N      = nzp_q.n;
   assign bus.Z      = nzp_q.z;
   assign bus.P      = nzp_q.p;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: stimulus pushes expected write-backs into a
// scoreboard, a monitor pops and compares them on every LD_REG pulse.
module tb_alu_execute_stage;
   import alu_pkg::*;

   logic Clk;
   logic Reset;
   int   cyc;
   int   n_checks;
   int   n_pass;

   alu_execute_stage_if bus ();

   alu_execute_stage dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] result;
      logic [2:0]  dr;
      logic [2:0]  nzp;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: every LD_REG pulse must match the oldest expected write-back;
   // the NZP it produces is checked one cycle later.
   initial begin
      logic       nzp_pending;
      logic [2:0] nzp_exp;
      string      nzp_name;
      exp_t       e;
      nzp_pending = 1'b0;
      nzp_exp     = 3'b000;
      forever begin
         @(negedge Clk);
         if (nzp_pending) begin
            check({nzp_name, "_nzp"}, {29'b0, bus.N, bus.Z, bus.P}, {29'b0, nzp_exp});
            nzp_pending = 1'b0;
         end
         if (bus.LD_REG) begin
            if (sb.size() == 0) begin
               check("unexpected_ld_reg", {31'b0, bus.LD_REG}, 32'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, "_result"}, {16'b0, bus.Result}, {16'b0, e.result});
               check({e.name, "_dr"}, {29'b0, bus.DR}, {29'b0, e.dr});
               check({e.name, "_latency"}, cyc, e.due);
               nzp_pending = 1'b1;
               nzp_exp     = e.nzp;
               nzp_name    = e.name;
            end
         end
      end
   end

   // Called at a negedge; returns at the first negedge with Busy low.
   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] imm, input logic imm_sel,
                         input logic [2:0] dr, input int exp_busy,
                         input logic expect_wb, input logic [15:0] exp_result,
                         input logic [2:0] exp_nzp, input logic corrupt);
      int busy_cycles;
      bus.Start  = 1'b1;
      bus.Op     = op;
      bus.SR1_In = a;
      bus.SR2_In = b;
      bus.Imm    = imm;
      bus.ImmSel = imm_sel;
      bus.DR_In  = dr;
      if (expect_wb) begin
         sb.push_back('{result: exp_result, dr: dr, nzp: exp_nzp, due: cyc + exp_busy, name: name});
      end
      @(negedge Clk);
      bus.Start = 1'b0;
      if (corrupt) begin
         bus.SR1_In = 16'hDEAD;
         bus.SR2_In = 16'hBEEF;
      end
      busy_cycles = 0;
      while (bus.Busy && busy_cycles < 100) begin
         busy_cycles++;
         @(negedge Clk);
      end
      check({name, "_busy_cycles"}, busy_cycles, exp_busy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset      = 1'b1;
      bus.Start  = 1'b0;
      bus.Op     = 2'b00;
      bus.SR1_In = '0;
      bus.SR2_In = '0;
      bus.Imm    = '0;
      bus.ImmSel = 1'b0;
      bus.DR_In  = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);

      check("rst_result", {16'b0, bus.Result}, 32'h0);
      check("rst_dr", {29'b0, bus.DR}, 32'h0);
      check("rst_ld_reg", {31'b0, bus.LD_REG}, 32'h0);
      check("rst_busy", {31'b0, bus.Busy}, 32'h0);
      check("rst_nzp", {29'b0, bus.N, bus.Z, bus.P}, 32'b010);

      run_op("add_imm", OP_ADD, 16'h0005, 16'h1234, 5'b11101, 1'b1, 3'd3, 1, 1'b1, 16'h0002, 3'b001, 1'b0);
      run_op("and_reg", OP_AND, 16'hF0F0, 16'h0FF0, 5'b00000, 1'b0, 3'd1, 1, 1'b1, 16'h00F0, 3'b001, 1'b0);
      run_op("not_ffff", OP_NOT, 16'hFFFF, 16'h1111, 5'b01111, 1'b1, 3'd2, 1, 1'b1, 16'h0000, 3'b010, 1'b0);
      run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 5'b00000, 1'b0, 3'd4, 1, 1'b1, 16'h8000, 3'b100, 1'b0);

      // Start held for four edges: only the two edges seen in IDLE are accepted.
      bus.Start  = 1'b1;
      bus.Op     = OP_ADD;
      bus.SR1_In = 16'h0001;
      bus.SR2_In = 16'h0001;
      bus.ImmSel = 1'b0;
      bus.DR_In  = 3'd5;
      sb.push_back('{result: 16'h0002, dr: 3'd5, nzp: 3'b001, due: cyc + 1, name: "held_1"});
      sb.push_back('{result: 16'h0002, dr: 3'd5, nzp: 3'b001, due: cyc + 3, name: "held_2"});
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         check($sformatf("held_busy_%0d", i), {31'b0, bus.Busy}, {31'b0, (i % 2 == 0)});
      end
      bus.Start = 1'b0;
      @(negedge Clk);

`ifdef ALU_MUL_EN
      run_op("mul_small", OP_MUL, 16'h0012, 16'h0034, 5'b00000, 1'b0, 3'd6, 17, 1'b1, 16'h03A8, 3'b001, 1'b1);
      run_op("mul_neg", OP_MUL, 16'hFFFF, 16'h0003, 5'b00000, 1'b0, 3'd7, 17, 1'b1, 16'hFFFD, 3'b100, 1'b1);

      // Reset five cycles into a multiply: outputs drop to reset values at once.
      bus.Start  = 1'b1;
      bus.Op     = OP_MUL;
      bus.SR1_In = 16'h0101;
      bus.SR2_In = 16'h0202;
      bus.DR_In  = 3'd2;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (4) @(negedge Clk);
      check("mid_mul_busy", {31'b0, bus.Busy}, 32'h1);
      #2 Reset = 1'b1;
      #1;
      check("mid_rst_busy", {31'b0, bus.Busy}, 32'h0);
      check("mid_rst_ld_reg", {31'b0, bus.LD_REG}, 32'h0);
      check("mid_rst_result", {16'b0, bus.Result}, 32'h0);
      check("mid_rst_dr", {29'b0, bus.DR}, 32'h0);
      check("mid_rst_nzp", {29'b0, bus.N, bus.Z, bus.P}, 32'b010);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      run_op("add_after_rst", OP_ADD, 16'h0002, 16'h0003, 5'b00000, 1'b0, 3'd1, 1, 1'b1, 16'h0005, 3'b001, 1'b0);
`else
      // Op=11 without the multiplier: one busy cycle, no write-back, state untouched.
      bus.Start  = 1'b1;
      bus.Op     = OP_MUL;
      bus.SR1_In = 16'h8888;
      bus.SR2_In = 16'h0000;
      bus.DR_In  = 3'd7;
      @(negedge Clk);
      bus.Start = 1'b0;
      check("nop_busy", {31'b0, bus.Busy}, 32'h1);
      check("nop_ld_reg", {31'b0, bus.LD_REG}, 32'h0);
      @(negedge Clk);
      check("nop_idle", {31'b0, bus.Busy}, 32'h0);
      check("nop_result", {16'b0, bus.Result}, 32'h0002);
      check("nop_dr", {29'b0, bus.DR}, 32'd5);
      check("nop_nzp", {29'b0, bus.N, bus.Z, bus.P}, 32'b001);
      run_op("add_after_nop", OP_ADD, 16'h0002, 16'h0003, 5'b00000, 1'b0, 3'd1, 1, 1'b1, 16'h0005, 3'b001, 1'b0);
`endif

      repeat (3) @(negedge Clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
